// File: rtl/tsm_monomial_pipe.sv
// Two-stage time-sharing masking: turns a 2-share masking of an NVAR-bit vector into
// 2-share maskings of all 2^NVAR-1 non-constant monomials, with valid/ready flow control.
module tsm_monomial_pipe #(
    parameter int NVAR = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NVAR-1:0]            in_share1,
    input  logic [NVAR-1:0]            in_share2,
    input  logic [(1 << NVAR) - 2:0]   rnd,
    output logic                       rnd_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(1 << NVAR) - 2:0]   out_share1,
    output logic [(1 << NVAR) - 2:0]   out_share2
);

    localparam int M = (1 << NVAR) - 1;

    // Handshake: a stage moves when its successor is empty or draining this cycle.
    // in_ready depends on out_ready and registered state only, never on in_valid.
    logic            stage2_free;
    logic            accept;
    logic            advance;

    logic            s1_valid_q, s1_valid_d;
    logic [M-1:0]    a_q, a_d;
    logic [M-1:0]    b_q, b_d;
    logic [NVAR-1:0] s2_q, s2_d;

    logic            out_valid_q, out_valid_d;
    logic [M-1:0]    o1_q, o1_d;
    logic [M-1:0]    o2_q, o2_d;

    logic [M-1:0]    prod1;
    logic [M:0]      p2;
    logic [M-1:0]    mono1;
    logic [M-1:0]    mono2;

    assign stage2_free = !out_valid_q || out_ready;
    assign in_ready    = !s1_valid_q || stage2_free;
    assign accept      = in_valid && in_ready;
    assign advance     = s1_valid_q && stage2_free;
    assign rnd_req     = accept;

    assign out_valid   = out_valid_q;
    assign out_share1  = o1_q;
    assign out_share2  = o2_q;

    // Products of share 1 only; share 2 is kept apart until after the register.
    always_comb begin
        prod1 = '0;
        for (int m = 1; m <= M; m++) begin
            prod1[m-1] = 1'b1;
            for (int i = 0; i < NVAR; i++) begin
                if (((m >> i) & 1) != 0) begin
                    prod1[m-1] = prod1[m-1] & in_share1[i];
                end
            end
        end
    end

    // Products of the registered share 2 over every variable subset; the empty set gives 1.
    always_comb begin
        p2 = '0;
        for (int t = 0; t <= M; t++) begin
            p2[t] = 1'b1;
            for (int i = 0; i < NVAR; i++) begin
                if (((t >> i) & 1) != 0) begin
                    p2[t] = p2[t] & s2_q[i];
                end
            end
        end
    end

    // Each output share combines one register set (A or B) with share-2 cofactors.
    always_comb begin
        mono1 = '0;
        mono2 = '0;
        for (int m = 1; m <= M; m++) begin
            mono1[m-1] = p2[m];
            for (int t = 1; t <= M; t++) begin
                if ((t & m) == t) begin
                    mono1[m-1] = mono1[m-1] ^ (a_q[t-1] & p2[m ^ t]);
                    mono2[m-1] = mono2[m-1] ^ (b_q[t-1] & p2[m ^ t]);
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_d       = s2_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = prod1 ^ rnd;
            b_d        = rnd;
            s2_d       = in_share2;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        o1_d        = o1_q;
        o2_d        = o2_q;
        if (advance) begin
            out_valid_d = 1'b1;
            o1_d        = mono1;
            o2_d        = mono2;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            o1_q        <= '0;
            o2_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            o1_q        <= o1_d;
            o2_q        <= o2_d;
        end
    end

endmodule

// File: tb/tb_tsm_monomial_pipe.sv
// Self-checking bench for tsm_monomial_pipe: directed vectors, back-pressure, reset,
// random flow control, NVAR=2/5 instances and a share-2 uniformity check.
module tb_tsm_monomial_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- NVAR=4 instance ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_share1 = '0;
    logic [3:0]  in_share2 = '0;
    logic [14:0] rnd = '0;
    logic        rnd_req;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [14:0] out_share1;
    logic [14:0] out_share2;

    tsm_monomial_pipe #(.NVAR(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_share1(in_share1), .in_share2(in_share2),
        .rnd(rnd), .rnd_req(rnd_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_share1(out_share1), .out_share2(out_share2)
    );

    // ---------------- NVAR=2 and NVAR=5 instances ----------------
    logic        one_r = 1'b1;
    logic        n2_in_valid = 1'b0, n2_in_ready, n2_rnd_req, n2_out_valid;
    logic [1:0]  n2_s1 = '0, n2_s2 = '0;
    logic [2:0]  n2_rnd = '0, n2_o1, n2_o2;
    logic        n5_in_valid = 1'b0, n5_in_ready, n5_rnd_req, n5_out_valid;
    logic [4:0]  n5_s1 = '0, n5_s2 = '0;
    logic [30:0] n5_rnd = '0, n5_o1, n5_o2;

    tsm_monomial_pipe #(.NVAR(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n2_in_valid), .in_ready(n2_in_ready),
        .in_share1(n2_s1), .in_share2(n2_s2),
        .rnd(n2_rnd), .rnd_req(n2_rnd_req),
        .out_valid(n2_out_valid), .out_ready(one_r),
        .out_share1(n2_o1), .out_share2(n2_o2)
    );

    tsm_monomial_pipe #(.NVAR(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n5_in_valid), .in_ready(n5_in_ready),
        .in_share1(n5_s1), .in_share2(n5_s2),
        .rnd(n5_rnd), .rnd_req(n5_rnd_req),
        .out_valid(n5_out_valid), .out_ready(one_r),
        .out_share1(n5_o1), .out_share2(n5_o2)
    );

    // ---------------- scoreboard state ----------------
    int chk_cnt = 0;
    int pass_cnt = 0;
    int req_cnt = 0;
    int out_cnt = 0;
    int out2_cnt = 0;
    int out5_cnt = 0;
    logic [30:0] exp_q[$];
    logic [30:0] exp2_q[$];
    logic [30:0] exp5_q[$];
    logic [14:0] cap_q[$];
    bit capture = 1'b0;
    bit rand_ready = 1'b0;
    bit ready_force = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: monomial m is 1 exactly when every variable in m is 1.
    function automatic logic [30:0] monos(input logic [4:0] a, input int nv);
        logic [30:0] r;
        logic [4:0]  mm;
        r = '0;
        for (int m = 1; m < (1 << nv); m++) begin
            mm = m[4:0];
            if ((a & mm) == mm) r[m-1] = 1'b1;
        end
        return r;
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // ---------------- compare process ----------------
    logic        prev_hold = 1'b0;
    logic [14:0] prev_o1 = '0, prev_o2 = '0;
    logic [30:0] e;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            chk("rnd_req_eq_accept", rnd_req, in_valid && in_ready);
            if (rnd_req) req_cnt++;
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_share1", out_share1, prev_o1);
                chk("hold_share2", out_share2, prev_o2);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (capture) cap_q.push_back(out_share2);
                if (exp_q.size() == 0) chk("out_with_empty_queue", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("mono_xor_n4", out_share1 ^ out_share2, e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(monos({1'b0, in_share1 ^ in_share2}, 4));
            prev_hold = out_valid && !out_ready;
            prev_o1 = out_share1;
            prev_o2 = out_share2;

            if (n2_out_valid) begin
                out2_cnt++;
                if (exp2_q.size() == 0) chk("out2_with_empty_queue", n2_out_valid, 0);
                else begin
                    e = exp2_q.pop_front();
                    chk("mono_xor_n2", n2_o1 ^ n2_o2, e);
                end
            end
            if (n2_in_valid && n2_in_ready) exp2_q.push_back(monos({3'b0, n2_s1 ^ n2_s2}, 2));

            if (n5_out_valid) begin
                out5_cnt++;
                if (exp5_q.size() == 0) chk("out5_with_empty_queue", n5_out_valid, 0);
                else begin
                    e = exp5_q.pop_front();
                    chk("mono_xor_n5", n5_o1 ^ n5_o2, e);
                end
            end
            if (n5_in_valid && n5_in_ready) exp5_q.push_back(monos(n5_s1 ^ n5_s2, 5));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] s1, input logic [3:0] s2, input logic [14:0] r);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_share1 = s1;
        in_share2 = s2;
        rnd = r;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic set_ready(input bit v);
        @(negedge clk);
        #1;
        rand_ready = 1'b0;
        ready_force = v;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(nm, (exp_q.size() == 0) && !out_valid, 1);
    endtask

    // Pipeline empty and out_ready high on entry.
    task automatic directed(input string nm, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [14:0] r, input logic [14:0] exp_x, input bit chk_s2);
        send(s1, s2, r);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({nm, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({nm, "_lat2"}, out_valid, 1);
        chk({nm, "_xor"}, out_share1 ^ out_share2, exp_x);
        if (chk_s2) chk({nm, "_share2"}, out_share2, 0);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        logic [14:0] h1, h2;
        logic [3:0] mk;
        logic [14:0] r;

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rnd_req", rnd_req, 0);
        chk("rst_share1", out_share1, 0);
        chk("rst_share2", out_share2, 0);
        #10;
        rst_n = 1'b1;

        // Directed vectors with hand-computed monomial vectors.
        directed("d_a1101", 4'b1011, 4'b0110, 15'h0000, 15'h1999, 1'b1);
        directed("d_a1111", 4'b0101, 4'b1010, 15'h1234, 15'h7fff, 1'b0);
        directed("d_a0000", 4'b0110, 4'b0110, 15'h7ace, 15'h0000, 1'b0);
        directed("d_a0011", 4'b1001, 4'b1010, 15'h5a5a, 15'h0007, 1'b0);

        // Back-pressure: two buffered, third refused until the output drains.
        base = out_cnt;
        set_ready(1'b0);
        send(4'b0001, 4'b1110, 15'h0f0f);
        send(4'b0011, 4'b0000, 15'h3c3c);
        @(negedge clk);
        in_share1 = 4'b1100;
        in_share2 = 4'b1010;
        rnd = 15'h6789;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_rnd_req", rnd_req, 0);
        chk("bp_out_valid", out_valid, 1);
        h1 = out_share1;
        h2 = out_share2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("bp_stable_share1", out_share1, h1);
            chk("bp_stable_share2", out_share2, h2);
            chk("bp_in_ready_held", in_ready, 0);
        end
        ready_force = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        idle();
        wait_drain("bp_drain");
        chk("bp_out_count", out_cnt - base, 3);

        // Random traffic with random downstream stalls.
        base = out_cnt;
        req_cnt = 0;
        rand_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 15'($urandom()));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rand_ready = 1'b0;
        ready_force = 1'b1;
        wait_drain("rand_drain");
        chk("rand_out_count", out_cnt - base, 1000);
        chk("rand_rnd_req_count", req_cnt, 1000);

        // Reset with two transactions in flight.
        set_ready(1'b0);
        send(4'b1111, 4'b0000, 15'h1111);
        send(4'b0101, 4'b0011, 15'h2222);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_s1_valid", dut.s1_valid_q, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_rnd_req", rnd_req, 0);
        chk("arst_share1", out_share1, 0);
        chk("arst_share2", out_share2, 0);
        exp_q.delete();
        ready_force = 1'b1;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        directed("post_rst", 4'b1000, 4'b0111, 15'h0000, 15'h7fff, 1'b1);

        // NVAR=2 exhaustive and NVAR=5 random.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n2_in_valid = 1'b1;
            n2_s1 = 2'(i);
            n2_s2 = 2'(i >> 2);
            n2_rnd = 3'($urandom());
        end
        @(negedge clk);
        n2_in_valid = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            n5_in_valid = 1'b1;
            n5_s1 = 5'($urandom());
            n5_s2 = 5'($urandom());
            n5_rnd = 31'($urandom());
        end
        @(negedge clk);
        n5_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("n2_out_count", out2_cnt, 16);
        chk("n5_out_count", out5_cnt, 4096);

        // Share 2 of singleton monomials: uniform and independent of a.
        cap_q.delete();
        capture = 1'b1;
        for (int k = 0; k < 256; k++) begin
            r = 15'($urandom());
            mk = 4'($urandom_range(0, 15));
            send(mk, mk ^ 4'b1101, r);
            mk = 4'($urandom_range(0, 15));
            send(mk, mk ^ 4'b0010, r);
        end
        idle();
        wait_drain("leak_drain");
        capture = 1'b0;
        chk("leak_capture_count", cap_q.size(), 512);
        if (cap_q.size() == 512) begin
            int ones[4];
            int diffs;
            int d;
            diffs = 0;
            for (int b = 0; b < 4; b++) ones[b] = 0;
            for (int k = 0; k < 256; k++) begin
                h1 = cap_q[2*k];
                h2 = cap_q[2*k+1];
                if (((h1 ^ h2) & 15'h008b) != 0) diffs++;
                ones[0] += int'(h1[0]);
                ones[1] += int'(h1[1]);
                ones[2] += int'(h1[3]);
                ones[3] += int'(h1[7]);
            end
            chk("leak_indep_of_a", diffs, 0);
            for (int b = 0; b < 4; b++) begin
                d = ones[b] - 128;
                chk("leak_chi2_singleton", (d * d) < 693, 1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
